mux_nto1_stream: RTL and testbench
==================================

Name: mux_nto1_stream

Overview:
- Parametrised successor to the team's 2:1 select mux.
- Merges N_CH valid/ready input channels of DATA_W bits onto one registered output channel.
- Two modes: direct select (sel_in picks the channel) and round-robin arbitration among requesting channels.
- Sits between multiple producers and a single consumer; one register stage at the output.

Parameters:
- DATA_W, 8, payload width per channel
- N_CH, 4, number of input channels (2..16)
- SEL_W, $clog2(N_CH) (localparam, not overridable), width of channel index

Ports:
- clk_in, input, 1, clock, rising edge
- rst_in, input, 1, synchronous active-high reset
- mode_in, input, 1, 0 = direct select, 1 = round-robin
- sel_in, input, SEL_W, channel index used in direct mode
- valid_in, input, N_CH, per-channel valid; bit i belongs to channel i
- data_in, input, N_CH*DATA_W, channel i occupies bits [i*DATA_W +: DATA_W]
- ready_out, output, N_CH, per-channel ready (combinational)
- valid_out, output, 1, output word valid (registered)
- data_out, output, DATA_W, output payload (registered)
- ch_out, output, SEL_W, index of the channel that supplied data_out (registered)
- ready_in, input, 1, downstream ready

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high; all state updates on the rising edge of clk_in.
- Reset values: valid_out=0, data_out=0, ch_out=0, rr_ptr=0. ready_out is combinational and reads 0 while rst_in=1.
- Output register:
  - valid_out is the only state bit: EMPTY when valid_out=0, FULL when valid_out=1.
  - load_en = !valid_out || ready_in. This gives full throughput: a new word may load in the same cycle the held word is accepted.
- Grant (combinational):
  - Direct mode: grant_vld = (sel_in < N_CH) && valid_in[sel_in]; grant = sel_in. An out-of-range sel_in gives no grant.
  - Round-robin mode: search channels rr_ptr, rr_ptr+1, ... N_CH-1, then 0 ... rr_ptr-1, with wrap-around. The first channel with valid_in set wins. grant_vld = |valid_in.
- Handshake:
  - ready_out[i] = !rst_in && load_en && grant_vld && (grant == i).
  - At most one ready_out bit is high in any cycle.
  - A transfer on channel i occurs when valid_in[i] && ready_out[i].
- Register update when load_en=1:
  - If grant_vld=1: data_out <= data_in[grant], ch_out <= grant, valid_out <= 1.
  - If grant_vld=0: valid_out <= 0; data_out and ch_out hold their values.
- Register update when load_en=0: everything holds. data_out and ch_out must stay stable while valid_out=1 and ready_in=0.
- Latency: an input is accepted in cycle T and appears on valid_out/data_out in cycle T+1.
- Round-robin pointer:
  - On each input transfer (in either mode), rr_ptr <= (grant == N_CH-1) ? 0 : grant+1.
  - No update without a transfer.
  - Switching modes does not reset rr_ptr.
- Mode and select timing: mode_in and sel_in are sampled combinationally every cycle, so a change affects the very next grant. Neither may alter a word already held in the output register.
- Simultaneous accept and load: when valid_out=1, ready_in=1 and grant_vld=1, the held word leaves and the new word loads in the same edge; valid_out stays 1.
- Reset mid-operation: any held word is discarded (valid_out=0), no ready_out is asserted during the reset cycle, and rr_ptr returns to 0.
- Inputs need not be held stable when ready_out is low. The block never assumes upstream holds data without a grant.

Decomposition:
- Shared package (mux_pkg):
  - constants MODE_DIRECT=1'b0 and MODE_RR=1'b1
  - a function for wrap-around pointer increment
- One sub-module is natural: rr_arbiter_n, a combinational round-robin arbiter.
  - inputs: request vector, pointer
  - outputs: grant index, grant_vld
- The top module holds the output register, the pointer register and the mode mux.

Test Plan:
- Reset: rst_in=1 for 2 cycles with all valid_in=1 -> valid_out=0, ready_out=0000, data_out=0, ch_out=0. After release, first grant goes to channel 0.
- Direct mode: mode_in=0, sel_in=2, valid_in=1111, data_in ch2=8'hA5, ready_in=1 -> ready_out=0100. Next cycle valid_out=1, data_out=8'hA5, ch_out=2. Other channels are never granted.
- Round-robin fairness: mode_in=1, valid_in=1111, data ch0..3 = 8'h10, 8'h21, 8'h32, 8'h43, ready_in=1 for 8 cycles -> ch_out sequence 0,1,2,3,0,1,2,3 and one word per cycle.
- Backpressure: round-robin, valid_out=1 with data 8'h21, ready_in=0 for 3 cycles -> data_out/ch_out stable and ready_out=0000. When ready_in=1, the held word completes and the next grant loads in the same edge.
- Skip and wrap: round-robin, rr_ptr=3, valid_in=0010 -> channel 1 granted; rr_ptr becomes 2. Then valid_in=1001 -> channel 3 granted, rr_ptr becomes 0.
- Reset mid-stream: valid_out=1 with ready_in=0, assert rst_in for 1 cycle -> next cycle valid_out=0, rr_ptr=0. Out-of-range sel_in with N_CH=3, sel_in=3 -> no ready_out and valid_out drains to 0.

Source files
------------

// File: rtl/mux_nto1_stream_pkg.sv
// Shared definitions for the N:1 stream multiplexer and its arbiter.
package mux_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Advance a channel index by one, wrapping from n-1 back to 0.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx == n - 32'd1) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/mux_nto1_stream_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr_in wins.
module rr_arbiter_n #(
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req_in,
  input  logic [SEL_W-1:0] ptr_in,
  output logic [SEL_W-1:0] grant_out,
  output logic             grant_vld_out
);

  // Walk the channels starting at the pointer, wrapping once; keep the first hit.
  always_comb begin
    int unsigned idx;
    idx           = 32'd0;
    grant_out     = '0;
    grant_vld_out = 1'b0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      idx = 32'(ptr_in) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!grant_vld_out && req_in[idx]) begin
        grant_out     = SEL_W'(idx);
        grant_vld_out = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_nto1_stream.sv
// N:1 valid/ready merge with direct-select or round-robin choice and one output register.
module mux_nto1_stream
  import mux_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int N_CH   = 4,
  localparam int SEL_W  = $clog2(N_CH)
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     mode_in,
  input  logic [SEL_W-1:0]         sel_in,
  input  logic [N_CH-1:0]          valid_in,
  input  logic [N_CH*DATA_W-1:0]   data_in,
  output logic [N_CH-1:0]          ready_out,
  output logic                     valid_out,
  output logic [DATA_W-1:0]        data_out,
  output logic [SEL_W-1:0]         ch_out,
  input  logic                     ready_in
);

  logic [DATA_W-1:0] ch_data [N_CH];

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SEL_W-1:0]  ch_q, ch_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic              load_en;
  logic [SEL_W-1:0]  rr_grant;
  logic              rr_vld;
  logic              dir_vld;
  logic [SEL_W-1:0]  grant;
  logic              grant_vld;
  logic [DATA_W-1:0] grant_data;
  logic              xfer;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
      assign ch_data[gi]   = data_in[gi*DATA_W +: DATA_W];
      assign ready_out[gi] = !rst_in && load_en && grant_vld && (grant == SEL_W'(gi));
    end
  endgenerate

  rr_arbiter_n #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_arb (
    .req_in        (valid_in),
    .ptr_in        (rr_ptr_q),
    .grant_out     (rr_grant),
    .grant_vld_out (rr_vld)
  );

  // The register can take a word when empty or when its current word is leaving.
  assign load_en = !valid_q || ready_in;

  // Direct grant: an index past the last channel matches nothing, so it never grants.
  always_comb begin
    dir_vld = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel_in == SEL_W'(i)) dir_vld = valid_in[i];
    end
  end

  // Mode mux, then pick the granted channel's payload.
  always_comb begin
    grant      = (mode_in == MODE_RR) ? rr_grant : sel_in;
    grant_vld  = (mode_in == MODE_RR) ? rr_vld   : dir_vld;
    grant_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant == SEL_W'(i)) grant_data = ch_data[i];
    end
  end

  assign xfer = |(valid_in & ready_out);

  // Next-state for the output register and the fairness pointer.
  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    ch_d     = ch_q;
    rr_ptr_d = rr_ptr_q;
    if (load_en) begin
      if (grant_vld) begin
        valid_d = 1'b1;
        data_d  = grant_data;
        ch_d    = grant;
      end else begin
        valid_d = 1'b0;
      end
    end
    if (xfer) rr_ptr_d = SEL_W'(wrap_inc(32'(grant), N_CH));
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      ch_q     <= '0;
      rr_ptr_q <= '0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      ch_q     <= ch_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign ch_out    = ch_q;

endmodule

// File: tb/tb_mux_nto1_stream.sv
// Self-checking bench: directed vector table, random run against a reference model,
// and an out-of-range select check on a 3-channel instance.
module tb_mux_nto1_stream;

  localparam int N = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 4-channel instance
  logic        rst = 1'b1, mode = 1'b0, ready = 1'b0;
  logic [1:0]  sel = '0;
  logic [3:0]  valid = '0;
  logic [31:0] data = '0;
  logic [3:0]  ready_o;
  logic        valid_o;
  logic [7:0]  data_o;
  logic [1:0]  ch_o;

  // 3-channel instance
  logic        rst3 = 1'b1, mode3 = 1'b0, ready3 = 1'b0;
  logic [1:0]  sel3 = '0;
  logic [2:0]  valid3 = '0;
  logic [23:0] data3 = '0;
  logic [2:0]  ready_o3;
  logic        valid_o3;
  logic [7:0]  data_o3;
  logic [1:0]  ch_o3;

  mux_nto1_stream #(.DATA_W(8), .N_CH(4)) dut (
    .clk_in(clk), .rst_in(rst), .mode_in(mode), .sel_in(sel), .valid_in(valid),
    .data_in(data), .ready_out(ready_o), .valid_out(valid_o), .data_out(data_o),
    .ch_out(ch_o), .ready_in(ready)
  );

  mux_nto1_stream #(.DATA_W(8), .N_CH(3)) dut3 (
    .clk_in(clk), .rst_in(rst3), .mode_in(mode3), .sel_in(sel3), .valid_in(valid3),
    .data_in(data3), .ready_out(ready_o3), .valid_out(valid_o3), .data_out(data_o3),
    .ch_out(ch_o3), .ready_in(ready3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: output slot contents plus the channel the next search starts at.
  bit         m_vld  = 1'b0;
  logic [7:0] m_data = '0;
  int         m_ch   = 0;
  int         m_ptr  = 0;

  // One clock of stimulus: drive after the falling edge, check ready before the
  // rising edge, then advance the model and check the registered outputs.
  task automatic run_cycle(input bit r, input bit m, input logic [1:0] s, input logic [3:0] v,
                           input logic [31:0] d, input bit rd, output logic [3:0] rdy_seen);
    bit   can_load, gv;
    int   g;
    logic [3:0] exp_rdy;
    @(negedge clk);
    rst = r; mode = m; sel = s; valid = v; data = d; ready = rd;
    can_load = !m_vld || rd;
    gv = 1'b0;
    g  = 0;
    if (m) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (!gv && v[c]) begin gv = 1'b1; g = c; end
      end
    end else begin
      g  = int'(s);
      gv = (g < N) && v[g];
    end
    exp_rdy = (!r && can_load && gv) ? 4'(1 << g) : 4'b0000;
    #1;
    rdy_seen = ready_o;
    check("model ready_out", 32'(ready_o), 32'(exp_rdy));
    @(posedge clk);
    if (r) begin
      m_vld = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0;
    end else if (can_load) begin
      if (gv) begin
        m_vld  = 1'b1;
        m_data = d[g*8 +: 8];
        m_ch   = g;
        m_ptr  = (g + 1) % N;
      end else begin
        m_vld = 1'b0;
      end
    end
    #1;
    check("model valid_out", 32'(valid_o), 32'(m_vld));
    check("model data_out", 32'(data_o), 32'(m_data));
    check("model ch_out", 32'(ch_o), 32'(m_ch));
  endtask

  typedef struct {
    bit         rst;
    bit         mode;
    logic [1:0] sel;
    logic [3:0] valid;
    logic [31:0] data;
    bit         ready;
    logic [3:0] e_rdy;
    bit         e_vo;
    logic [7:0] e_do;
    logic [1:0] e_ch;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input bit m, input logic [1:0] s, input logic [3:0] v,
                     input logic [31:0] d, input bit rd, input logic [3:0] er,
                     input bit evo, input logic [7:0] edo, input logic [1:0] ech);
    vec_t t;
    t = '{r, m, s, v, d, rd, er, evo, edo, ech};
    vecs.push_back(t);
  endtask

  initial begin
    logic [31:0] dd;
    logic [31:0] dx;
    logic [3:0]  rs;
    dd = 32'h43322110;
    dx = 32'h00A50000;

    // reset with all channels requesting
    add(1, 1, 0, 4'b1111, dd, 1, 4'b0000, 0, 8'h00, 0);
    add(1, 1, 0, 4'b1111, dd, 1, 4'b0000, 0, 8'h00, 0);
    add(0, 1, 0, 4'b1111, dd, 1, 4'b0001, 1, 8'h10, 0);
    // direct select of channel 2
    add(0, 0, 2, 4'b1111, dx, 1, 4'b0100, 1, 8'hA5, 2);
    add(0, 0, 2, 4'b1111, dx, 1, 4'b0100, 1, 8'hA5, 2);
    // reset, then round-robin fairness over 8 cycles
    add(1, 1, 0, 4'b1111, dd, 1, 4'b0000, 0, 8'h00, 0);
    for (int i = 0; i < 8; i++)
      add(0, 1, 0, 4'b1111, dd, 1, 4'(1 << (i % 4)), 1, dd[(i%4)*8 +: 8], 2'(i % 4));
    // backpressure holding 8'h21 from channel 1
    add(0, 1, 0, 4'b1111, dd, 1, 4'b0001, 1, 8'h10, 0);
    add(0, 1, 0, 4'b1111, dd, 1, 4'b0010, 1, 8'h21, 1);
    for (int i = 0; i < 3; i++)
      add(0, 1, 0, 4'b1111, dd, 0, 4'b0000, 1, 8'h21, 1);
    add(0, 1, 0, 4'b1111, dd, 1, 4'b0100, 1, 8'h32, 2);
    // skip and wrap from pointer 3
    add(0, 1, 0, 4'b0010, dd, 1, 4'b0010, 1, 8'h21, 1);
    add(0, 1, 0, 4'b1001, dd, 1, 4'b1000, 1, 8'h43, 3);
    // drain, then load into an empty register while downstream is stalled
    add(0, 1, 0, 4'b0000, dd, 1, 4'b0000, 0, 8'h43, 3);
    add(0, 1, 0, 4'b0001, dd, 0, 4'b0001, 1, 8'h10, 0);
    // reset mid-stream with a stalled word, pointer returns to 0
    add(0, 1, 0, 4'b1111, dd, 0, 4'b0000, 1, 8'h10, 0);
    add(1, 1, 0, 4'b1111, dd, 0, 4'b0000, 0, 8'h00, 0);
    add(0, 1, 0, 4'b1111, dd, 1, 4'b0001, 1, 8'h10, 0);
    // mode switch while stalled leaves the held word alone
    add(0, 0, 3, 4'b1111, dd, 0, 4'b0000, 1, 8'h10, 0);

    foreach (vecs[i]) begin
      run_cycle(vecs[i].rst, vecs[i].mode, vecs[i].sel, vecs[i].valid, vecs[i].data,
                vecs[i].ready, rs);
      check($sformatf("vec%0d ready_out", i), 32'(rs), 32'(vecs[i].e_rdy));
      check($sformatf("vec%0d valid_out", i), 32'(valid_o), 32'(vecs[i].e_vo));
      check($sformatf("vec%0d data_out", i), 32'(data_o), 32'(vecs[i].e_do));
      check($sformatf("vec%0d ch_out", i), 32'(ch_o), 32'(vecs[i].e_ch));
      $display("[TB] vec %0d: rdy=%b vo=%b do=%h ch=%0d", i, rs, valid_o, data_o, ch_o);
    end

    // randomized run against the model
    for (int i = 0; i < 1500; i++) begin
      run_cycle($urandom_range(0, 49) == 0, 1'($urandom), 2'($urandom), 4'($urandom),
                $urandom, $urandom_range(0, 3) != 0, rs);
    end
    $display("[TB] random phase: %0d checks so far", n_tests);

    // 3-channel instance: out-of-range select never grants
    @(negedge clk);
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0; mode3 = 1'b0; sel3 = 2'd1; valid3 = 3'b111; data3 = 24'h332211; ready3 = 1'b1;
    #1 check("n3 sel1 ready_out", 32'(ready_o3), 32'(3'b010));
    @(posedge clk); #1;
    check("n3 sel1 valid_out", 32'(valid_o3), 32'd1);
    check("n3 sel1 data_out", 32'(data_o3), 32'h22);
    $display("[TB] n3 sel=1: vo=%b do=%h ch=%0d", valid_o3, data_o3, ch_o3);
    @(negedge clk);
    sel3 = 2'd3;
    #1 check("n3 sel3 ready_out", 32'(ready_o3), 32'(3'b000));
    @(posedge clk); #1;
    check("n3 sel3 valid_out", 32'(valid_o3), 32'd0);
    check("n3 sel3 ch_out", 32'(ch_o3), 32'd1);
    $display("[TB] n3 sel=3: vo=%b do=%h ch=%0d", valid_o3, data_o3, ch_o3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
